// File: rtl/ppct_pkg.sv
// Shared constants, operation record and helpers for the PPCT multiplier scheduler.
package ppct_pkg;

  localparam int PPCT_N_REQ = 4;
  localparam int PPCT_W     = 8;
  localparam int PPCT_TW    = 4;

  function automatic int ppct_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PPCT_IDW = ppct_id_w(PPCT_N_REQ);

  typedef struct packed {
    logic [PPCT_W-1:0]   x;
    logic [PPCT_W-1:0]   y;
    logic [PPCT_TW-1:0]  theta;
    logic [PPCT_IDW-1:0] id;
  } ppct_op_t;

endpackage

// File: rtl/ppct_mul_sched_trunc_mul.sv
// Combinational column-truncated W x W multiplier; product columns below theta are dropped.
module ppct_trunc_mul #(
  parameter int W  = 8,
  parameter int TW = 4
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic [TW-1:0]  theta,
  output logic [2*W-1:0] z
);

  logic [2*W-1:0]        col_mask;
  logic [W-1:0][2*W-1:0] rows;

  // Shifting past 2W clears the mask, so large theta naturally yields zero.
  always_comb col_mask = {(2*W){1'b1}} << theta;

  for (genvar i = 0; i < W; i++) begin : g_row
    assign rows[i] = y[i] ? (({{W{1'b0}}, x} << i) & col_mask) : '0;
  end

  always_comb begin
    z = '0;
    for (int i = 0; i < W; i++) z = z + rows[i];
  end

endmodule

// File: rtl/ppct_mul_sched.sv
// Round-robin scheduler sharing one two-stage truncated multiplier among N_REQ requesters.
// Optional PPCT_STATS_EN adds a saturating response-handshake counter on stat_ops.
module ppct_mul_sched
  import ppct_pkg::*;
#(
  parameter int N_REQ = PPCT_N_REQ,
  parameter int W     = PPCT_W,
  parameter int TW    = PPCT_TW,
  localparam int IDW  = ppct_id_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  input  logic [N_REQ*TW-1:0] req_theta,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*W-1:0]     rsp_z,
`ifdef PPCT_STATS_EN
  output logic [31:0]        stat_ops,
`endif
  output logic [IDW-1:0]     rsp_id
);

  typedef struct packed {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [TW-1:0]  theta;
    logic [IDW-1:0] id;
  } op_t;

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  op_t              s1_q, s1_d;
  logic [2*W-1:0]   rsp_z_q, rsp_z_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   gnt_idx;
  logic             any_vld;
  int               idx;
  logic             s2_adv, s1_adv, accept;
  op_t              sel_op;
  logic [2*W-1:0]   mul_z;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!any_vld && req_valid[idx]) begin
        any_vld    = 1'b1;
        gnt_idx    = IDW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign s2_adv    = !s2_v_q || rsp_ready;
  assign s1_adv    = !s1_v_q || s2_adv;
  assign accept    = any_vld && s1_adv && !rst;
  assign req_ready = accept ? grant : '0;

  always_comb begin
    sel_op.x     = req_x[gnt_idx*W +: W];
    sel_op.y     = req_y[gnt_idx*W +: W];
    sel_op.theta = req_theta[gnt_idx*TW +: TW];
    sel_op.id    = gnt_idx;
  end

  ppct_trunc_mul #(.W(W), .TW(TW)) u_mul (
    .x     (s1_q.x),
    .y     (s1_q.y),
    .theta (s1_q.theta),
    .z     (mul_z)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    s1_v_d   = s1_v_q;
    s1_d     = s1_q;
    s2_v_d   = s2_v_q;
    rsp_z_d  = rsp_z_q;
    rsp_id_d = rsp_id_q;
    if (accept)
      rr_ptr_d = (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + IDW'(1);
    if (s1_adv) begin
      s1_v_d = accept;
      if (accept) s1_d = sel_op;
    end
    // Result regs only change on a real S1->S2 move, keeping them stable under stall.
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        rsp_z_d  = mul_z;
        rsp_id_d = s1_q.id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      s1_v_q   <= 1'b0;
      s1_q     <= '0;
      s2_v_q   <= 1'b0;
      rsp_z_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      s1_v_q   <= s1_v_d;
      s1_q     <= s1_d;
      s2_v_q   <= s2_v_d;
      rsp_z_q  <= rsp_z_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;

`ifdef PPCT_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;

  always_comb begin
    stat_ops_d = stat_ops_q;
    if (s2_v_q && rsp_ready && stat_ops_q != 32'hFFFF_FFFF)
      stat_ops_d = stat_ops_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stat_ops_q <= '0;
    else     stat_ops_q <= stat_ops_d;
  end

  assign stat_ops = stat_ops_q;
`endif

endmodule

// File: tb/tb_ppct_mul_sched.sv
// Randomized self-checking bench for ppct_mul_sched against an order/occupancy scoreboard model.
module tb_ppct_mul_sched;
  import ppct_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TW = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x, req_y;
  logic [N*TW-1:0] req_theta;
  logic           rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_z;
  logic [1:0]     rsp_id;
`ifdef PPCT_STATS_EN
  logic [31:0]    stat_ops;
`endif

  ppct_mul_sched #(.N_REQ(N), .W(W), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_theta (req_theta),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
`ifdef PPCT_STATS_EN
    .stat_ops  (stat_ops),
`endif
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] z; logic [1:0] id; } exp_t;

  exp_t        q[$];
  int          ptr;
  int          nvec, nerr;
  int          hs_cnt;
  bit          stall_prev;
  logic [15:0] prev_z;
  logic [1:0]  prev_id;

  logic [N-1:0]  nv;
  logic [W-1:0]  nx [N];
  logic [W-1:0]  ny [N];
  logic [TW-1:0] nt [N];
  bit            nrr;

  // Reference: literal sum of partial-product bits whose column reaches theta.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input int th);
    int acc;
    acc = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (i + j >= th && x[j] && y[i]) acc += (1 << (i + j));
    return 16'(acc);
  endfunction

  task automatic randomize_ops();
    for (int k = 0; k < N; k++) begin
      nx[k] = 8'($urandom);
      ny[k] = 8'($urandom);
      nt[k] = 4'($urandom_range(0, 15));
    end
  endtask

  // One clock: drive at negedge, check just after, update the model for the coming edge.
  task automatic step(input bit do_rst);
    logic [N-1:0] exp_rdy;
    int g, id;
    exp_t e;
    @(negedge clk);
    rst       = do_rst;
    req_valid = nv;
    for (int k = 0; k < N; k++) begin
      req_x[k*W +: W]      = nx[k];
      req_y[k*W +: W]      = ny[k];
      req_theta[k*TW +: TW] = nt[k];
    end
    rsp_ready = nrr;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      id = (ptr + k) % N;
      if (g < 0 && nv[id]) g = id;
    end
    exp_rdy = '0;
    if (!do_rst && g >= 0 && (q.size() < 2 || nrr)) exp_rdy[g] = 1'b1;
    nvec++;
    if (req_ready !== exp_rdy) begin
      nerr++;
      $display("FAIL req_ready: got %b expected %b (t=%0t)", req_ready, exp_rdy, $time);
    end
    if (!do_rst) begin
      if (stall_prev) begin
        nvec++;
        if (rsp_z !== prev_z || rsp_id !== prev_id) begin
          nerr++;
          $display("FAIL rsp_stable: got z=%0d id=%0d expected z=%0d id=%0d", rsp_z, rsp_id, prev_z, prev_id);
        end
      end
      if (rsp_valid === 1'b1) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL rsp_spurious: got valid with z=%0d id=%0d expected no response", rsp_z, rsp_id);
        end else if (rsp_z !== q[0].z || rsp_id !== q[0].id) begin
          nerr++;
          $display("FAIL rsp_data: got z=%0d id=%0d expected z=%0d id=%0d", rsp_z, rsp_id, q[0].z, q[0].id);
          if (nrr) void'(q.pop_front());
        end else if (nrr) begin
          void'(q.pop_front());
          hs_cnt++;
        end
      end else if (rsp_valid !== 1'b0) begin
        nerr++;
        $display("FAIL rsp_valid_x: got %b expected 0 or 1", rsp_valid);
      end
    end
    stall_prev = !do_rst && (rsp_valid === 1'b1) && !nrr;
    prev_z     = rsp_z;
    prev_id    = rsp_id;
    if (!do_rst && exp_rdy != '0) begin
      e.z  = ref_mul(nx[g], ny[g], int'(nt[g]));
      e.id = 2'(g);
      q.push_back(e);
      ptr = (g + 1) % N;
    end
    if (do_rst) begin
      q.delete();
      ptr        = 0;
      hs_cnt     = 0;
      stall_prev = 0;
    end
  endtask

  task automatic drain();
    nv  = '0;
    nrr = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) step(0);
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d ops outstanding expected 0", q.size());
      q.delete();
    end
    step(0);
  endtask

  task automatic do_reset();
    nv  = '0;
    nrr = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    step(0);
    nvec++;
    if (rsp_valid !== 1'b0 || rsp_z !== 16'd0 || rsp_id !== 2'd0) begin
      nerr++;
      $display("FAIL reset_state: got v=%b z=%0d id=%0d expected 0/0/0", rsp_valid, rsp_z, rsp_id);
    end
  endtask

  task automatic test_latency();
    nv = 4'b0001; nrr = 1'b1;
    nx[0] = 8'd255; ny[0] = 8'd255; nt[0] = 4'd0;
    step(0);
    nv = '0;
    step(0);
    nvec++;
    if (rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL latency_early: got rsp_valid=%b expected 0", rsp_valid);
    end
    step(0);
    nvec++;
    if (rsp_valid !== 1'b1 || rsp_z !== 16'd65025 || rsp_id !== 2'd0) begin
      nerr++;
      $display("FAIL latency_exact: got v=%b z=%0d id=%0d expected 1/65025/0", rsp_valid, rsp_z, rsp_id);
    end
    drain();
  endtask

  task automatic test_directed();
    logic [7:0] dx [4] = '{8'd255, 8'd3, 8'd3, 8'd255};
    logic [7:0] dy [4] = '{8'd255, 8'd3, 8'd3, 8'd255};
    logic [3:0] dt [4] = '{4'd8, 4'd2, 4'd8, 4'd14};
    nrr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nv = 4'b0001;
      nx[0] = dx[i]; ny[0] = dy[i]; nt[0] = dt[i];
      step(0);
    end
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    nv = 4'b1111; nrr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      randomize_ops();
      step(0);
      nvec++;
      if (req_ready !== 4'(1 << (i % N))) begin
        nerr++;
        $display("FAIL rr_order: got %b expected %b at cycle %0d", req_ready, 4'(1 << (i % N)), i);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back_stall();
    int acc;
    acc = 0;
    nv = 4'b1111; nrr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      randomize_ops();
      step(0);
      if (req_ready != '0) acc++;
    end
    nvec++;
    if (acc != 2) begin
      nerr++;
      $display("FAIL stall_accepts: got %0d expected 2", acc);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    nv = 4'b1111; nrr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      step(0);
    end
    step(1);
    nv = '0; nrr = 1'b1;
    step(0);
    nvec++;
    if (rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_flush: got rsp_valid=%b expected 0", rsp_valid);
    end
    nv = 4'b1111;
    randomize_ops();
    step(0);
    nvec++;
    if (req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL reset_rrptr: got %b expected 0001", req_ready);
    end
    drain();
    nv = 4'b0100;
    randomize_ops();
    step(0);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      nv  = 4'($urandom);
      nrr = ($urandom_range(0, 9) < 7);
      randomize_ops();
      step(0);
    end
    drain();
  endtask

`ifdef PPCT_STATS_EN
  task automatic test_stats();
    do_reset();
    nrr = 1'b0;
    nv  = 4'b1111;
    for (int i = 0; i < 3; i++) begin randomize_ops(); step(0); end
    nrr = 1'b1;
    for (int i = 0; i < 8; i++) begin randomize_ops(); step(0); end
    drain();
    nvec++;
    if (stat_ops !== 32'(hs_cnt)) begin
      nerr++;
      $display("FAIL stat_ops: got %0d expected %0d", stat_ops, hs_cnt);
    end
  endtask
`endif

  initial begin
    nvec = 0; nerr = 0; ptr = 0; hs_cnt = 0; stall_prev = 0;
    prev_z = '0; prev_id = '0;
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_theta = '0; rsp_ready = 1'b0;
    nv = '0; nrr = 1'b0;
    for (int k = 0; k < N; k++) begin nx[k] = '0; ny[k] = '0; nt[k] = '0; end
    test_reset();
    test_latency();
    test_directed();
    test_round_robin();
    test_back_to_back_stall();
    test_reset_midflight();
    test_random();
`ifdef PPCT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
